cmp_arbiter: RTL and testbench



---
 rtl/cmp_arbiter.sv | 171 +++++++++++++++++
 tb/tb_cmp_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_arbiter.sv
// ============================================================================
//  Module   : cmp_arbiter
//  Purpose  : Round-robin arbiter sharing one N-bit magnitude comparator
//             among R requesters. It accepts one compare request per cycle
//             and registers the eq/lt/gt result with the winner's ID behind
//             a valid/ready output channel.
//  Ports    : clk, rst_n          - clock, asynchronous active-low reset
//             req_valid[R]        - per-requester operand pair present
//             req_a/req_b[R*N]    - operands, requester i at [i*N +: N]
//             req_ready[R]        - one-hot (or zero) grant
//             rsp_valid/rsp_ready - result channel handshake
//             rsp_id              - requester index of the shown result
//             rsp_eq/lt/gt        - comparison result (exactly one set)
//             busy                - result pending or any request present
//  Config   : define CMP_SIGNED_EN for two's-complement signed compare;
//             unsigned compare otherwise.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_arbiter #(
   parameter int N = 8,
   parameter int R = 4,
   localparam int IDW = $clog2(R)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [R-1:0]     req_valid,
   input  logic [R*N-1:0]   req_a,
   input  logic [R*N-1:0]   req_b,
   output logic [R-1:0]     req_ready,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [IDW-1:0]   rsp_id,
   output logic             rsp_eq,
   output logic             rsp_lt,
   output logic             rsp_gt,
   output logic             busy
);

   typedef enum logic [0:0] {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [IDW-1:0]   id_q, id_d;
   logic             eq_q, eq_d;
   logic             lt_q, lt_d;
   logic             gt_q, gt_d;

   logic [N-1:0]     w_a_arr [R];
   logic [N-1:0]     w_b_arr [R];
   logic [N-1:0]     w_a_sel;
   logic [N-1:0]     w_b_sel;
   logic [IDW-1:0]   w_cand;
   logic [IDW-1:0]   w_gnt_idx;
   logic             w_gnt_found;
   logic             w_can_accept;
   logic             w_accept;
   logic             w_eq, w_lt, w_gt;

   // Unpack the flat operand buses into per-requester words.
   generate
      for (genvar gi = 0; gi < R; gi++) begin : g_unpack
         assign w_a_arr[gi] = req_a[gi*N +: N];
         assign w_b_arr[gi] = req_b[gi*N +: N];
      end
   endgenerate

   // The result register can take a new value if it is empty or is being
   // drained this very cycle.
   assign w_can_accept = (state_q == S_EMPTY) || rsp_ready;

   // Round-robin search: first valid requester at or after ptr, wrapping.
   // R is a power of two, so the IDW-bit add wraps modulo R for free.
   always_comb begin
      w_gnt_found = 1'b0;
      w_gnt_idx   = '0;
      w_cand      = '0;
      for (int k = 0; k < R; k++) begin
         w_cand = ptr_q + IDW'(k);
         if (!w_gnt_found && req_valid[w_cand]) begin
            w_gnt_found = 1'b1;
            w_gnt_idx   = w_cand;
         end
      end
   end

   // rst_n gates the grant so nothing is handshaken while reset is held.
   assign w_accept  = rst_n && w_can_accept && w_gnt_found;
   assign req_ready = w_accept ? (R'(1) << w_gnt_idx) : '0;

   // Shared comparator on the winner's operands.
   assign w_a_sel = w_a_arr[w_gnt_idx];
   assign w_b_sel = w_b_arr[w_gnt_idx];
   assign w_eq    = (w_a_sel == w_b_sel);
`ifdef CMP_SIGNED_EN
   assign w_lt    = ($signed(w_a_sel) <  $signed(w_b_sel));
   assign w_gt    = ($signed(w_a_sel) >  $signed(w_b_sel));
`else
   assign w_lt    = (w_a_sel < w_b_sel);
   assign w_gt    = (w_a_sel > w_b_sel);
`endif

   // Next-state and result-load logic.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      eq_d    = eq_q;
      lt_d    = lt_q;
      gt_d    = gt_q;

      case (state_q)
         S_EMPTY: begin
            if (w_accept) begin
               state_d = S_FULL;
            end
         end
         S_FULL: begin
            // Drain and accept in the same cycle keeps FULL (no bubble).
            if (w_accept) begin
               state_d = S_FULL;
            end else if (rsp_ready) begin
               state_d = S_EMPTY;
            end
         end
         default: begin
            state_d = S_EMPTY;
         end
      endcase

      if (w_accept) begin
         id_d  = w_gnt_idx;
         eq_d  = w_eq;
         lt_d  = w_lt;
         gt_d  = w_gt;
         ptr_d = w_gnt_idx + IDW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_EMPTY;
         ptr_q   <= '0;
         id_q    <= '0;
         eq_q    <= 1'b0;
         lt_q    <= 1'b0;
         gt_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         eq_q    <= eq_d;
         lt_q    <= lt_d;
         gt_q    <= gt_d;
      end
   end

   assign rsp_valid = (state_q == S_FULL);
   assign rsp_id    = id_q;
   assign rsp_eq    = eq_q;
   assign rsp_lt    = lt_q;
   assign rsp_gt    = gt_q;
   assign busy      = rsp_valid || (|req_valid);

endmodule

`default_nettype wire

// File: tb/tb_cmp_arbiter.sv
// ============================================================================
//  Module   : tb_cmp_arbiter
//  Purpose  : Self-checking bench for cmp_arbiter: directed scenarios plus
//             randomized traffic against a behavioural reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmp_arbiter;

   localparam int N   = 8;
   localparam int R   = 4;
   localparam int IDW = $clog2(R);

   logic             clk;
   logic             rst_n;
   logic [R-1:0]     req_valid;
   logic [R*N-1:0]   req_a;
   logic [R*N-1:0]   req_b;
   logic [R-1:0]     req_ready;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [IDW-1:0]   rsp_id;
   logic             rsp_eq;
   logic             rsp_lt;
   logic             rsp_gt;
   logic             busy;

   cmp_arbiter #(.N(N), .R(R)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_eq    (rsp_eq),
      .rsp_lt    (rsp_lt),
      .rsp_gt    (rsp_gt),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: a result slot, the round-robin start point, and
   // per-requester counts of foreign accepts while waiting.
   bit           m_full;
   int           m_id;
   logic [N-1:0] m_a, m_b;
   int           m_ptr;
   int           wait_cnt [R];
   logic [R-1:0] last_acc;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
   endtask

   // Returns {gt, lt, eq} from integer arithmetic on the operand values.
   function automatic logic [2:0] exp_cmp(input logic [N-1:0] a, input logic [N-1:0] b);
      int sa, sb;
      sa = int'(a);
      sb = int'(b);
`ifdef CMP_SIGNED_EN
      if (sa >= 2**(N-1)) sa = sa - 2**N;
      if (sb >= 2**(N-1)) sb = sb - 2**N;
`endif
      return {sa > sb, sa < sb, sa == sb};
   endfunction

   task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
      req_a[i*N +: N] = a;
      req_b[i*N +: N] = b;
   endtask

   task automatic model_reset();
      m_full = 0;
      m_id   = 0;
      m_a    = '0;
      m_b    = '0;
      m_ptr  = 0;
      for (int i = 0; i < R; i++) wait_cnt[i] = 0;
      last_acc = '0;
   endtask

   // One clock cycle: called at a falling edge with inputs already applied.
   task automatic cycle();
      int           g;
      logic [R-1:0] exp_rdy;
      logic [R-1:0] acc;
      #1;
      check("rsp_valid", rsp_valid, m_full);
      if (m_full) begin
         check("rsp_id", rsp_id, m_id);
         check("rsp_cmp", {rsp_gt, rsp_lt, rsp_eq}, exp_cmp(m_a, m_b));
      end
      check("busy", busy, m_full || (|req_valid));
      g = -1;
      if (!m_full || rsp_ready) begin
         for (int k = 0; k < R; k++) begin
            if (g < 0 && req_valid[(m_ptr + k) % R]) g = (m_ptr + k) % R;
         end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", req_ready, exp_rdy);
      acc      = req_valid & req_ready;
      last_acc = acc;
      @(posedge clk);
      // Fairness on the observed handshakes: fewer than R foreign accepts
      // may pass while a request stays asserted.
      for (int i = 0; i < R; i++) begin
         if (acc[i]) begin
            check("fair_wait", wait_cnt[i] < R, 1);
            wait_cnt[i] = 0;
         end else if (req_valid[i]) begin
            if (|acc) wait_cnt[i]++;
         end else begin
            wait_cnt[i] = 0;
         end
      end
      if (g >= 0) begin
         m_full = 1;
         m_id   = g;
         m_a    = req_a[g*N +: N];
         m_b    = req_b[g*N +: N];
         m_ptr  = (g + 1) % R;
      end else if (m_full && rsp_ready) begin
         m_full = 0;
      end
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_req_ready", req_ready, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [R-1:0]       e_rdy;
   logic [IDW+2:0]     snap;
   logic [N-1:0]       ra;

   initial begin
      rst_n     = 1'b0;
      req_valid = '1;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      model_reset();

      // Reset state
      #3;
      check("reset_req_ready", req_ready, 0);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_rsp_id", rsp_id, 0);
      check("reset_rsp_cmp", {rsp_gt, rsp_lt, rsp_eq}, 3'b000);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;

      // Single request, equal operands
      set_req(0, 8'd123, 8'd123);
      req_valid = 4'b0001;
      #1 check("single_grant", req_ready, 4'b0001);
      cycle();
      req_valid = '0;
      #1;
      check("single_valid", rsp_valid, 1);
      check("single_id", rsp_id, 0);
      check("single_cmp", {rsp_gt, rsp_lt, rsp_eq}, 3'b001);

      // Compare values (back-to-back accepts)
      set_req(1, 8'h10, 8'h20);
      req_valid = 4'b0010;
      cycle();
      req_valid = '0;
      #1;
      check("cmp_10_20", {rsp_gt, rsp_lt, rsp_eq}, 3'b010);
      check("cmp_10_20_id", rsp_id, 1);
      set_req(2, 8'hFF, 8'h01);
      req_valid = 4'b0100;
      cycle();
      req_valid = '0;
      #1;
`ifdef CMP_SIGNED_EN
      check("cmp_ff_01", {rsp_gt, rsp_lt, rsp_eq}, 3'b010);
`else
      check("cmp_ff_01", {rsp_gt, rsp_lt, rsp_eq}, 3'b100);
`endif
      check("cmp_ff_01_id", rsp_id, 2);

      // Mid-operation reset while FULL with id=2
      rsp_ready = 1'b0;
      cycle();
      pulse_reset();

      // Round-robin with all requesters asserted
      rsp_ready = 1'b1;
      for (int i = 0; i < R; i++) set_req(i, N'($urandom), N'($urandom));
      req_valid = '1;
      for (int k = 0; k < 5; k++) begin
         #1;
         e_rdy = '0;
         e_rdy[k % R] = 1'b1;
         check("rr_grant", req_ready, e_rdy);
         if (k > 0) check("rr_id", rsp_id, (k - 1) % R);
         cycle();
      end

      // Back-pressure: FULL with id 0, ptr 1
      rsp_ready = 1'b0;
      #1 snap = {rsp_id, rsp_gt, rsp_lt, rsp_eq};
      for (int k = 0; k < 5; k++) begin
         #1;
         check("bp_ready", req_ready, 0);
         check("bp_hold", {rsp_id, rsp_gt, rsp_lt, rsp_eq}, snap);
         cycle();
      end
      rsp_ready = 1'b1;
      #1 check("bp_release", req_ready, 4'b0010);
      cycle();
      req_valid = '0;
      #1;
      check("bp_nobubble_valid", rsp_valid, 1);
      check("bp_nobubble_id", rsp_id, 1);
      cycle();

      // Withdrawn request
      pulse_reset();
      rsp_ready = 1'b1;
      req_valid = 4'b0001;
      cycle();
      rsp_ready = 1'b0;
      req_valid = 4'b0010;
      cycle();
      cycle();
      req_valid = '0;
      rsp_ready = 1'b1;
      cycle();
      #1 check("wd_empty", rsp_valid, 0);
      cycle();
      #1 check("wd_no_rsp", rsp_valid, 0);
      req_valid = '1;
      #1 check("wd_ptr", req_ready, 4'b0010);
      cycle();

      // Randomized traffic
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < R; i++) begin
            ra = N'($urandom);
            if (last_acc[i]) begin
               if ($urandom_range(1, 0) == 1) req_valid[i] = 1'b0;
               else set_req(i, ra, ($urandom_range(3, 0) == 0) ? ra : N'($urandom));
            end else if (!req_valid[i]) begin
               if ($urandom_range(99, 0) < 40) begin
                  set_req(i, ra, ($urandom_range(3, 0) == 0) ? ra : N'($urandom));
                  req_valid[i] = 1'b1;
               end
            end else if ($urandom_range(99, 0) < 5) begin
               req_valid[i] = 1'b0;
            end
         end
         rsp_ready = ($urandom_range(99, 0) < 70);
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
